stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with a valid/ready handshake on every input channel and on the output.
- Two selection modes: fixed (external select) and round-robin arbitration.
- One registered output stage, so the block drops between producers and a single consumer on the board-level datapath.
- Successor to the basic 2:1 combinational mux: it generalises width and channel count and adds flow control and arbitration.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH), select/channel-index width. Derived; not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_ch  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low. Sampled only on the rising edge of clk.
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = 0.
- Reset mid-operation: a held output word is discarded; no partial transfers survive.
- Output register is a two-state machine:
  - EMPTY (out_valid = 0): can_load = 1.
  - FULL (out_valid = 1): can_load = out_ready.
- Grant generation (combinational, one-hot grant[NCH-1:0]):
  - mode 0: grant[sel] = in_valid[sel]; all other bits are 0.
  - mode 1: grant the first i with in_valid[i] = 1, scanning rr_ptr, rr_ptr+1, … modulo NCH.
  - No valid input: grant = 0.
- in_ready[i] = grant[i] & can_load. Ready never depends on out_valid of another channel.
- Transfer on channel g (in_valid[g] & in_ready[g]), at the next edge:
  - out_data ← in_data[g], out_ch ← g, out_valid ← 1.
  - mode 1 only: rr_ptr ← g+1, wrapping NCH-1 → 0. rr_ptr is unchanged by mode-0 transfers and by idle cycles.
- Output drain, FULL with out_ready = 1:
  - If no transfer occurs that cycle, out_valid ← 0.
  - If a transfer occurs, the new word replaces the old one in the same edge. This gives full throughput, one word per clock.
- Stall, FULL with out_ready = 0:
  - out_data and out_ch are held stable.
  - All in_ready = 0.
- Latency: an input accepted at edge k appears on the output after edge k, i.e. one cycle.
- mode or sel changes:
  - Take effect on the grant in the same cycle.
  - Never alter a word already held in the output register.
- Edge cases:
  - sel ≥ NCH (non-power-of-2 NCH): no grant.
  - All channels valid in mode 1: strict rotation 0,1,…,NCH-1,0.
  - Single valid channel in mode 1: that channel is granted every cycle.

Optional Feature:
- Macro STREAM_MUX_LOCK_EN: packet lock.
- When defined:
  - Adds input port in_last (NCH bits).
  - Once a channel transfers a beat with in_last = 0, the grant is locked to that channel in both modes. mode and sel are ignored while locked.
  - The lock releases after the beat with in_last = 1 transfers.
  - rr_ptr advances only on that last beat.
  - Adds output out_last (registered alongside out_data, reset value 0).
  - Reset clears the lock.
- When undefined: no in_last or out_last ports; every beat is arbitrated independently, as described above.

Test Plan:
1. Reset: hold rst_n = 0 for 3 edges with all in_valid = 1 → out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0 during reset. Release with WIDTH = 8, NCH = 4.
2. Fixed mode: mode = 0, sel = 2, in_data[2] = 8'hA5, in_valid = 4'b0100, out_ready = 1 → after one edge out_valid = 1, out_data = A5, out_ch = 2. sel = 1 with in_valid[1] = 0 → in_ready = 0 and out_valid drops to 0 the following edge.
3. Round-robin fairness: mode = 1, all in_valid = 1, channel data = 8'h10 + i, out_ready = 1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 and out_data 10,11,12,13,10,…
4. Back-pressure: out_ready = 0 for 4 cycles while FULL with out_data = 8'h11 → out_data stays 11, all in_ready = 0, rr_ptr unchanged. On release, next grant resumes rotation at the channel after 1.
5. Skip and wrap: mode = 1, rr_ptr = 3, in_valid = 4'b0010 → channel 1 granted, rr_ptr becomes 2. Then in_valid = 4'b1001 → channel 3 granted, then channel 0.
6. Reset mid-stall: FULL with out_ready = 0, assert rst_n = 0 for 1 edge → out_valid = 0, rr_ptr = 0. With STREAM_MUX_LOCK_EN, a 3-beat packet on channel 2 (in_last on beat 3) while channel 0 is valid → out_ch = 2,2,2, then 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a registered output stage.
// It supports fixed-select (mode = 0) and round-robin (mode = 1) arbitration.
// Optional packet lock is enabled by defining STREAM_MUX_LOCK_EN. That adds the in_last and out_last ports.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state;
    logic [SELW-1:0]   rr_ptr;
    logic [NCH-1:0]    rr_grant;
    logic [SELW-1:0]   rr_idx;
    logic              rr_hit;
    int unsigned       rr_pos;
    logic [NCH-1:0]    grant;
    logic [SELW-1:0]   gidx;
    logic              sel_ok;
    logic              can_load;
    logic              xfer;
    logic              adv_ptr;
    logic [SELW-1:0]   next_ptr;
    logic [WIDTH-1:0]  word;

`ifdef STREAM_MUX_LOCK_EN
    logic              locked;
    logic [SELW-1:0]   lock_ch;
`endif

    assign sel_ok    = (int'(sel) < NCH);
    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) | out_ready;
    assign in_ready  = grant & {NCH{can_load & rst_n}};
    assign xfer      = |in_ready;
    assign next_ptr  = (gidx == SELW'(NCH - 1)) ? '0 : gidx + SELW'(1);

    // Round-robin search: the first valid channel at or after rr_ptr, with wrap-around.
    always_comb begin
        rr_grant = '0;
        rr_idx   = '0;
        rr_hit   = 1'b0;
        rr_pos   = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            rr_pos = int'(rr_ptr) + k;
            if (rr_pos >= NCH) rr_pos = rr_pos - NCH;
            if (!rr_hit && in_valid[rr_pos]) begin
                rr_hit           = 1'b1;
                rr_grant[rr_pos] = 1'b1;
                rr_idx           = SELW'(rr_pos);
            end
        end
    end

    // Final one-hot grant and its index, chosen by mode (or by an active packet lock).
    always_comb begin
        grant = '0;
        gidx  = '0;
        if (mode) begin
            grant = rr_grant;
            gidx  = rr_idx;
        end else if (sel_ok) begin
            grant[sel] = in_valid[sel];
            gidx       = sel;
        end
`ifdef STREAM_MUX_LOCK_EN
        if (locked) begin
            grant          = '0;
            grant[lock_ch] = in_valid[lock_ch];
            gidx           = lock_ch;
        end
`endif
    end

    // Select the granted channel's data word.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (SELW'(i) == gidx) word = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Pointer advance rule: on every mode-1 beat, or only on a packet's last beat when locking is enabled.
    always_comb begin
`ifdef STREAM_MUX_LOCK_EN
        adv_ptr = xfer & mode & in_last[gidx];
`else
        adv_ptr = xfer & mode;
`endif
    end

    // Output register FSM. When full and drained, a new word replaces the old one on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
`ifdef STREAM_MUX_LOCK_EN
            out_last <= 1'b0;
            locked   <= 1'b0;
            lock_ch  <= '0;
`endif
        end else begin
            if (xfer) begin
                state    <= FULL;
                out_data <= word;
                out_ch   <= gidx;
                if (adv_ptr) rr_ptr <= next_ptr;
`ifdef STREAM_MUX_LOCK_EN
                out_last <= in_last[gidx];
                locked   <= ~in_last[gidx];
                lock_ch  <= gidx;
`endif
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and random stimulus, checked against a transaction-level reference model.
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    logic [WIDTH-1:0]     chan_data [NCH];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_valid;
    int m_data;
    int m_ch;
    int m_ptr;

    stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the specification's rules would grant, or -1 for none.
    function automatic int pick(input bit md, input int s, input logic [NCH-1:0] v, input int ptr);
        if (!md) return (s < NCH && v[s]) ? s : -1;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (ptr + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check ready before the edge, advance the model at the edge, check outputs after it.
    task automatic cycle();
        int g;
        bit can;
        logic [NCH-1:0] exp_rdy;
        for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = chan_data[i];
        #1;
        g   = pick(mode, int'(sel), in_valid, m_ptr);
        can = !m_valid || out_ready;
        exp_rdy = '0;
        if (rst_n && can && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (can && g >= 0) begin
            m_valid = 1;
            m_data  = int'(chan_data[g]);
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % NCH;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    task automatic drive(input bit md, input int s, input logic [NCH-1:0] v, input bit ordy);
        mode      = md;
        sel       = SELW'(s);
        in_valid  = v;
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) chan_data[i] = 8'h10 + 8'(i);
        drive(1'b1, 0, '1, 1'b1);
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;

        // Hold reset for 3 edges with every channel valid.
        repeat (3) cycle();
        check("rst_out_data", 32'(out_data), 32'h0);
        rst_n = 1'b1;

        // Fixed mode
        chan_data[2] = 8'hA5;
        drive(1'b0, 2, 4'b0100, 1'b1);
        cycle();
        check("fixed_data", 32'(out_data), 32'hA5);
        check("fixed_ch", 32'(out_ch), 32'd2);
        drive(1'b0, 1, 4'b0100, 1'b1);
        cycle();
        check("fixed_drop", 32'(out_valid), 32'd0);

        // Round-robin fairness, all channels valid
        chan_data[2] = 8'h12;
        drive(1'b1, 0, '1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            cycle();
            check("rr_seq_ch", 32'(out_ch), 32'(n % NCH));
        end
        cycle();
        cycle();
        check("rr_pre_stall", 32'(out_data), 32'h11);

        // Back-pressure while full
        out_ready = 1'b0;
        repeat (4) cycle();
        check("stall_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        cycle();
        check("resume_ch", 32'(out_ch), 32'd2);

        // Skip and wrap from rr_ptr = 3
        in_valid = 4'b0010;
        cycle();
        check("skip_ch", 32'(out_ch), 32'd1);
        in_valid = 4'b1001;
        cycle();
        check("wrap_ch3", 32'(out_ch), 32'd3);
        cycle();
        check("wrap_ch0", 32'(out_ch), 32'd0);

        // Reset during a stall
        out_ready = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 0, '1, 1'b1);
        cycle();
        check("post_rst_ch", 32'(out_ch), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(63) != 0);
            drive(1'($urandom_range(1)), int'($urandom_range(NCH - 1)),
                  NCH'($urandom), ($urandom_range(3) != 0));
            for (int i = 0; i < NCH; i++) chan_data[i] = WIDTH'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
